ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Serializes one command byte (for example LED set 0xED or reset 0xFF) onto the keyboard clock/data lines.
- Protocol sequence:
  - Inhibit the bus.
  - Issue request-to-send.
  - Shift the frame on device-generated clock edges.
  - Check the device acknowledge bit.
- Sits beside the keyboard receive path and shares the same open-drain pins.
- While `busy` is high, the receive path ignores the bus.

---
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, shifts one
// command byte out on device clock falls and checks the device acknowledge.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       sysClock,
  input  logic       sysReset_n,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       busy,
  output logic       txDone,
  output logic       txError,
  input  logic       keyClkIn,
  input  logic       keyDataIn,
  output logic       keyClkDriveLow,
  output logic       keyDataDriveLow
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] RTS       = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic [2:0]      state;
  logic            clkMeta, clkSync, clkPrev, dataMeta, dataSync;
  logic            clkFall, timeoutHit;
  logic [InhW-1:0] inhCnt;
  logic [ToW-1:0]  toCnt;
  logic [3:0]      bitCnt, bitNext;
  logic [7:0]      shiftReg;
  logic            parityBit, ackSeen;

  // Idle-high synchronizers so reset never fakes a clock fall.
  always_ff @(posedge sysClock or negedge sysReset_n) begin
    if (!sysReset_n) begin
      clkMeta  <= 1'b1;
      clkSync  <= 1'b1;
      clkPrev  <= 1'b1;
      dataMeta <= 1'b1;
      dataSync <= 1'b1;
    end else begin
      clkMeta  <= keyClkIn;
      clkSync  <= clkMeta;
      clkPrev  <= clkSync;
      dataMeta <= keyDataIn;
      dataSync <= dataMeta;
    end
  end

  assign clkFall    = clkPrev & ~clkSync;
  assign timeoutHit = ((state == SEND) || (state == WAIT_IDLE)) && (toCnt == ToLast);
  assign bitNext    = bitCnt + 4'd1;
  assign txReady    = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge sysClock or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state           <= IDLE;
      inhCnt          <= '0;
      toCnt           <= '0;
      bitCnt          <= 4'd0;
      shiftReg        <= 8'h00;
      parityBit       <= 1'b0;
      ackSeen         <= 1'b0;
      keyClkDriveLow  <= 1'b0;
      keyDataDriveLow <= 1'b0;
      txDone          <= 1'b0;
      txError         <= 1'b0;
    end else begin
      txDone  <= 1'b0;
      txError <= 1'b0;
      if (timeoutHit) begin
        // Timeout wins over a coincident clock fall.
        keyClkDriveLow  <= 1'b0;
        keyDataDriveLow <= 1'b0;
        txDone          <= 1'b1;
        txError         <= 1'b1;
        state           <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            keyClkDriveLow  <= 1'b0;
            keyDataDriveLow <= 1'b0;
            if (txValid) begin
              shiftReg       <= txData;
              parityBit      <= ~^txData;
              bitCnt         <= 4'd0;
              inhCnt         <= '0;
              ackSeen        <= 1'b0;
              keyClkDriveLow <= 1'b1;
              state          <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inhCnt == InhLast) begin
              keyDataDriveLow <= 1'b1;
              state           <= RTS;
            end else begin
              inhCnt <= inhCnt + 1'b1;
            end
          end
          RTS: begin
            // Data stays low as the start bit once the clock is released.
            keyClkDriveLow <= 1'b0;
            toCnt          <= '0;
            state          <= SEND;
          end
          SEND: begin
            toCnt <= toCnt + 1'b1;
            if (clkFall) begin
              if (bitCnt != 4'd11) bitCnt <= bitNext;
              if (bitNext <= 4'd8) begin
                keyDataDriveLow <= ~shiftReg[0];
                shiftReg        <= {1'b0, shiftReg[7:1]};
              end else if (bitNext == 4'd9) begin
                keyDataDriveLow <= ~parityBit;
              end else if (bitNext == 4'd10) begin
                keyDataDriveLow <= 1'b0;
              end else begin
                ackSeen         <= ~dataSync;
                keyDataDriveLow <= 1'b0;
                state           <= WAIT_IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            keyClkDriveLow  <= 1'b0;
            keyDataDriveLow <= 1'b0;
            toCnt           <= toCnt + 1'b1;
            if (clkSync && dataSync) begin
              txDone  <= 1'b1;
              txError <= ~ackSeen;
              state   <= IDLE;
            end
          end
          default: begin
            keyClkDriveLow  <= 1'b0;
            keyDataDriveLow <= 1'b0;
            state           <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and a
// scoreboard checks each captured frame and the completion status.
module tb_ps2_host_tx;

  logic       sysClock = 1'b0;
  logic       sysReset_n = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
  logic       txReady, busy, txDone, txError;
  logic       keyClkIn, keyDataIn, keyClkDriveLow, keyDataDriveLow;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       err;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[5];

  assign keyClkIn  = ~(keyClkDriveLow | ~devClk);
  assign keyDataIn = ~(keyDataDriveLow | ~devData);

  always #5 sysClock = ~sysClock;

  ps2_host_tx #(
    .INHIBIT_CYCLES(10),
    .TIMEOUT_CYCLES(4000)
  ) dut (
    .sysClock        (sysClock),
    .sysReset_n      (sysReset_n),
    .txData          (txData),
    .txValid         (txValid),
    .txReady         (txReady),
    .busy            (busy),
    .txDone          (txDone),
    .txError         (txError),
    .keyClkIn        (keyClkIn),
    .keyDataIn       (keyDataIn),
    .keyClkDriveLow  (keyClkDriveLow),
    .keyDataDriveLow (keyDataDriveLow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Accept a byte, then measure the inhibit/RTS phase until the host releases the clock.
  task automatic acceptAndInhibit(input logic [7:0] d, input logic spam);
    int clkLow, overlap, g;
    @(negedge sysClock);
    chk("ready_before_accept", txReady, 1'b1);
    txData  = d;
    txValid = 1'b1;
    @(posedge sysClock);
    #1;
    chk("accept_clk_drive", keyClkDriveLow, 1'b1);
    chk("accept_busy", busy, 1'b1);
    if (spam) txData = 8'hAA;
    else txValid = 1'b0;
    clkLow = 0;
    overlap = 0;
    g = 0;
    while (keyClkDriveLow && g < 100) begin
      clkLow++;
      if (keyDataDriveLow) overlap++;
      @(posedge sysClock);
      #1;
      g++;
    end
    chk("clk_low_cycles", clkLow, 11);
    chk("rts_overlap", overlap, 1);
    chk("start_bit_drive", keyDataDriveLow, 1'b1);
  endtask

  // Device side: sample data at the end of each high phase, then pull the clock low.
  task automatic runDevice(input logic ack, input int falls, output logic [10:0] bits);
    bits = '1;
    repeat (50) @(posedge sysClock);
    for (int i = 0; i < falls; i++) begin
      bits[i] = keyDataIn;
      if (i == 10 && ack) devData = 1'b0;
      repeat (2) @(posedge sysClock);
      devClk = 1'b0;
      repeat (50) @(posedge sysClock);
      if (i != falls - 1) begin
        devClk = 1'b1;
        repeat (48) @(posedge sysClock);
      end
    end
  endtask

  task automatic sendFrame(input vec_t v, input logic spam);
    logic [10:0] bits;
    exp_t e;
    int g;
    logic readyBad;
    sbQ.push_back('{data: v.data, par: v.par, err: v.err});
    acceptAndInhibit(v.data, spam);
    runDevice(v.ack, 11, bits);
    devClk  = 1'b1;
    devData = 1'b1;
    g = 0;
    readyBad = 1'b0;
    while (!txDone && g < 500) begin
      if (txReady) readyBad = 1'b1;
      @(posedge sysClock);
      #1;
      g++;
    end
    if (spam) txValid = 1'b0;
    e = sbQ.pop_front();
    chk("done_seen", txDone, 1'b1);
    chk("ready_low_while_busy", readyBad, 1'b0);
    chk("tx_error", txError, e.err);
    chk("start_bit", bits[0], 1'b0);
    chk("data_byte", bits[8:1], e.data);
    chk("parity_bit", bits[9], e.par);
    chk("stop_bit", bits[10], 1'b1);
    chk("ready_after_done", txReady, 1'b1);
    @(posedge sysClock);
    #1;
    chk("done_one_cycle", txDone, 1'b0);
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    logic [10:0] bits;
    int cnt;
    logic doneSeen;

    vecs[0] = '{data: 8'hED, ack: 1'b1, par: 1'b1, err: 1'b0};
    vecs[1] = '{data: 8'h01, ack: 1'b1, par: 1'b0, err: 1'b0};
    vecs[2] = '{data: 8'h00, ack: 1'b1, par: 1'b1, err: 1'b0};
    vecs[3] = '{data: 8'h55, ack: 1'b0, par: 1'b1, err: 1'b1};
    vecs[4] = '{data: 8'h3C, ack: 1'b1, par: 1'b1, err: 1'b0};

    #23;
    chk("rst_clk_drive", keyClkDriveLow, 1'b0);
    chk("rst_data_drive", keyDataDriveLow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", txDone, 1'b0);
    chk("rst_error", txError, 1'b0);
    chk("rst_ready", txReady, 1'b1);
    @(negedge sysClock);
    sysReset_n = 1'b1;
    repeat (3) @(posedge sysClock);

    for (int i = 0; i < 5; i++) sendFrame(vecs[i], 1'b0);

    // No device clocking after RTS: timeout after exactly 4000 cycles in SEND.
    acceptAndInhibit(8'h3C, 1'b0);
    cnt = 0;
    while (!txDone && cnt < 5000) begin
      @(posedge sysClock);
      #1;
      cnt++;
    end
    chk("timeout_cycles", cnt, 4000);
    chk("timeout_error", txError, 1'b1);
    chk("timeout_clk_drive", keyClkDriveLow, 1'b0);
    chk("timeout_data_drive", keyDataDriveLow, 1'b0);
    chk("timeout_ready", txReady, 1'b1);
    repeat (2) @(posedge sysClock);

    // Reset mid-frame after the 4th device fall.
    acceptAndInhibit(8'h00, 1'b0);
    runDevice(1'b1, 4, bits);
    chk("pre_reset_data_drive", keyDataDriveLow, 1'b1);
    #3;
    sysReset_n = 1'b0;
    #1;
    chk("reset_clk_drive", keyClkDriveLow, 1'b0);
    chk("reset_data_drive", keyDataDriveLow, 1'b0);
    chk("reset_busy", busy, 1'b0);
    devClk = 1'b1;
    doneSeen = 1'b0;
    repeat (5) begin
      @(negedge sysClock);
      if (txDone) doneSeen = 1'b1;
    end
    sysReset_n = 1'b1;
    repeat (10) begin
      @(negedge sysClock);
      if (txDone) doneSeen = 1'b1;
    end
    chk("reset_no_done", doneSeen, 1'b0);
    sendFrame('{data: 8'hFF, ack: 1'b1, par: 1'b1, err: 1'b0}, 1'b0);

    // txValid with 0xAA held throughout a 0xF4 transfer must be ignored.
    sendFrame('{data: 8'hF4, ack: 1'b1, par: 1'b0, err: 1'b0}, 1'b1);
    chk("scoreboard_empty", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
